// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for a byte-wide external SRAM with per-port lock.
// Optional lock watchdog: define MEM_ARB_LOCK_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int MAX_LOCK  = 64,
  parameter bit RESET_PRI = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_lock0,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [7:0]        i_wdata0,
  output logic              o_gnt0,
  output logic [7:0]        o_rd_data0,
  output logic              o_rd_valid0,
  input  logic              i_req1,
  input  logic              i_lock1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [7:0]        i_wdata1,
  output logic              o_gnt1,
  output logic [7:0]        o_rd_data1,
  output logic              o_rd_valid1,
  output logic [ADDR_W-1:0] o_mem_addr,
  inout  wire  [7:0]        io_mem_data,
  output logic              o_mem_clk,
  output logic              o_mem_write,
  output logic              o_lock_err
);

  logic              r_own_v;
  logic              r_owner;
  logic              r_last;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_write;
  logic [7:0]        r_wdata;
  logic              r_rd_pend0;
  logic              r_rd_pend1;
  logic              r_rd_valid0;
  logic              r_rd_valid1;
  logic [7:0]        r_rd_data0;
  logic [7:0]        r_rd_data1;

  logic w_gnt0;
  logic w_gnt1;
  logic w_acc0;
  logic w_acc1;
  logic w_own_v_nx;
  logic w_owner_nx;
  logic w_tmo;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_own_v) begin
      w_gnt0 = i_req0 & ~r_owner;
      w_gnt1 = i_req1 & r_owner;
    end else if (i_req0 && i_req1) begin
      w_gnt0 = r_last;
      w_gnt1 = ~r_last;
    end else begin
      w_gnt0 = i_req0;
      w_gnt1 = i_req1;
    end
  end

  assign w_acc0 = i_req0 & w_gnt0;
  assign w_acc1 = i_req1 & w_gnt1;

  // A watchdog release overrides whatever the accepted access asked for.
  always_comb begin
    w_own_v_nx = r_own_v;
    w_owner_nx = r_owner;
    if (w_acc0) begin
      w_own_v_nx = i_lock0;
      w_owner_nx = 1'b0;
    end else if (w_acc1) begin
      w_own_v_nx = i_lock1;
      w_owner_nx = 1'b1;
    end
    if (w_tmo) w_own_v_nx = 1'b0;
  end

`ifdef MEM_ARB_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [CW-1:0] r_cnt;
  logic          r_lock_err;
  logic          w_chg;

  assign w_tmo = r_own_v && (r_cnt == CW'(MAX_LOCK - 1));
  assign w_chg = (w_own_v_nx != r_own_v) ||
                 (w_own_v_nx && (w_owner_nx != r_owner));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_lock_err <= 1'b0;
    end else begin
      r_lock_err <= w_tmo;
      if (!w_own_v_nx || w_chg) r_cnt <= '0;
      else                      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_lock_err = r_lock_err;
`else
  assign w_tmo      = 1'b0;
  assign o_lock_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_own_v     <= 1'b0;
      r_owner     <= 1'b0;
      r_last      <= ~RESET_PRI;
      r_mem_addr  <= '0;
      r_mem_write <= 1'b0;
      r_wdata     <= '0;
      r_rd_pend0  <= 1'b0;
      r_rd_pend1  <= 1'b0;
      r_rd_valid0 <= 1'b0;
      r_rd_valid1 <= 1'b0;
      r_rd_data0  <= '0;
      r_rd_data1  <= '0;
    end else begin
      r_own_v     <= w_own_v_nx;
      r_owner     <= w_owner_nx;
      r_mem_write <= 1'b0;
      r_rd_pend0  <= 1'b0;
      r_rd_pend1  <= 1'b0;
      if (w_acc0) begin
        r_mem_addr  <= i_addr0;
        r_mem_write <= i_we0;
        r_wdata     <= i_wdata0;
        r_last      <= 1'b0;
        r_rd_pend0  <= ~i_we0;
      end else if (w_acc1) begin
        r_mem_addr  <= i_addr1;
        r_mem_write <= i_we1;
        r_wdata     <= i_wdata1;
        r_last      <= 1'b1;
        r_rd_pend1  <= ~i_we1;
      end
      r_rd_valid0 <= r_rd_pend0;
      r_rd_valid1 <= r_rd_pend1;
      if (r_rd_pend0) r_rd_data0 <= io_mem_data;
      if (r_rd_pend1) r_rd_data1 <= io_mem_data;
    end
  end

  assign io_mem_data = r_mem_write ? r_wdata : 8'bz;
  assign o_mem_clk   = ~i_clk;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_write = r_mem_write;
  assign o_gnt0      = w_gnt0;
  assign o_gnt1      = w_gnt1;
  assign o_rd_data0  = r_rd_data0;
  assign o_rd_data1  = r_rd_data1;
  assign o_rd_valid0 = r_rd_valid0;
  assign o_rd_valid1 = r_rd_valid1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural SRAM on the pins.
// Memory preload: mem[a] = a ^ 8'h5A.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, lock0, we0;
  logic [15:0] addr0;
  logic [7:0]  wdata0;
  logic        req1, lock1, we1;
  logic [15:0] addr1;
  logic [7:0]  wdata1;
  logic        gnt0, gnt1;
  logic [7:0]  rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1;
  logic [15:0] mem_addr;
  wire  [7:0]  mem_data;
  logic        mem_clk;
  logic        mem_write;
  logic        lock_err;

  logic [7:0]  mem [256];
  int          checks;
  int          errors;

  mem_port_arbiter #(
    .ADDR_W(16),
    .MAX_LOCK(4),
    .RESET_PRI(1'b0)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req0(req0),
    .i_lock0(lock0),
    .i_we0(we0),
    .i_addr0(addr0),
    .i_wdata0(wdata0),
    .o_gnt0(gnt0),
    .o_rd_data0(rd_data0),
    .o_rd_valid0(rd_valid0),
    .i_req1(req1),
    .i_lock1(lock1),
    .i_we1(we1),
    .i_addr1(addr1),
    .i_wdata1(wdata1),
    .o_gnt1(gnt1),
    .o_rd_data1(rd_data1),
    .o_rd_valid1(rd_valid1),
    .o_mem_addr(mem_addr),
    .io_mem_data(mem_data),
    .o_mem_clk(mem_clk),
    .o_mem_write(mem_write),
    .o_lock_err(lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data = mem_write ? 8'bz : mem[mem_addr[7:0]];

  always @(posedge mem_clk)
    if (mem_write) mem[mem_addr[7:0]] <= mem_data;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    req0 = 0; lock0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; lock1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // reset state
    tick;
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_rd_valid0", 32'(rd_valid0), 32'h0);
    chk("rst_rd_valid1", 32'(rd_valid1), 32'h0);
    chk("rst_rd_data0", 32'(rd_data0), 32'h0);
    chk("rst_rd_data1", 32'(rd_data1), 32'h0);
    chk("rst_lock_err", 32'(lock_err), 32'h0);
    chk("rst_gnt_idle", 32'({gnt0, gnt1}), 32'h0);
    chk("mem_clk_inv", 32'(mem_clk), 32'h0);
    rst_n = 1'b1;

    // write 0xA5 @0x0010 then read it back
    req0 = 1; we0 = 1; addr0 = 16'h0010; wdata0 = 8'hA5;
    #1 chk("wr_gnt0", 32'({gnt0, gnt1}), 32'h2);
    tick;
    chk("wr_mem_write", 32'(mem_write), 32'h1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h0010);
    chk("wr_mem_data", 32'(mem_data), 32'hA5);
    we0 = 0;
    #1 chk("rd_gnt0", 32'(gnt0), 32'h1);
    tick;
    chk("rd_mem_write", 32'(mem_write), 32'h0);
    chk("rd_mem_addr", 32'(mem_addr), 32'h0010);
    chk("rd_valid_early", 32'(rd_valid0), 32'h0);
    req0 = 0;
    tick;
    chk("rd_valid0", 32'(rd_valid0), 32'h1);
    chk("rd_data0", 32'(rd_data0), 32'hA5);
    tick;
    chk("rd_valid0_pulse", 32'(rd_valid0), 32'h0);
    chk("rd_data0_hold", 32'(rd_data0), 32'hA5);

    // round-robin from reset
    rst_n = 0;
    #1 rst_n = 1;
    req0 = 1; addr0 = 16'h0020;
    req1 = 1; addr1 = 16'h0030;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_gnt", 32'({gnt0, gnt1}), (k % 2 == 0) ? 32'h2 : 32'h1);
      tick;
      chk("rr_addr", 32'(mem_addr), (k % 2 == 0) ? 32'h20 : 32'h30);
      chk("rr_no_write", 32'(mem_write), 32'h0);
      if (k > 0) begin
        chk("rr_valid", 32'({rd_valid0, rd_valid1}),
            ((k - 1) % 2 == 0) ? 32'h2 : 32'h1);
        if ((k - 1) % 2 == 0) chk("rr_data0", 32'(rd_data0), 32'h7A);
        else                  chk("rr_data1", 32'(rd_data1), 32'h6A);
      end
    end

    // locked burst on port 0 while port 1 waits
    for (int i = 0; i < 3; i++) begin
      addr0 = 16'(i);
      lock0 = (i < 2);
      #1 chk("lk_gnt", 32'({gnt0, gnt1}), 32'h2);
      tick;
      if (i == 2) chk("lk_data_1", 32'(rd_data0), 32'h5B);
    end
    addr0 = 16'h0003;
    lock0 = 0;
    #1 chk("lk_release_gnt1", 32'({gnt0, gnt1}), 32'h1);
    tick;
    chk("lk_data_2", 32'(rd_data0), 32'h58);
    req0 = 0; req1 = 0;
    tick;
    chk("lk_p1_valid", 32'(rd_valid1), 32'h1);
    chk("lk_p1_data", 32'(rd_data1), 32'h6A);
    tick;

    // port 1 takes lock then idles while port 0 requests
    req1 = 1; lock1 = 1; addr1 = 16'h0030;
    #1 chk("own_gnt1", 32'({gnt0, gnt1}), 32'h1);
    tick;
    req1 = 0; lock1 = 0;
    req0 = 1; addr0 = 16'h0005;
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      #1 chk("tmo_wait_gnt0", 32'(gnt0), 32'h0);
      chk("tmo_wait_err", 32'(lock_err), 32'h0);
      tick;
    end
    chk("tmo_hold_gnt0", 32'(gnt0), 32'h0);
    tick;
    chk("tmo_err_pulse", 32'(lock_err), 32'h1);
    chk("tmo_gnt0", 32'(gnt0), 32'h1);
    req0 = 0;
    tick;
    chk("tmo_err_clear", 32'(lock_err), 32'h0);
`else
    for (int i = 0; i < 8; i++) begin
      #1 chk("nolk_gnt0", 32'(gnt0), 32'h0);
      chk("nolk_err", 32'(lock_err), 32'h0);
      tick;
    end
    req0 = 0;
    req1 = 1;
    #1 chk("unlock_gnt1", 32'(gnt1), 32'h1);
    tick;
    req1 = 0;
    tick;
`endif

    // reset in the middle of a port 1 write
    req0 = 0;
    req1 = 1; we1 = 1; lock1 = 0; addr1 = 16'h0040; wdata1 = 8'hC3;
    #1 chk("rw_gnt1", 32'(gnt1), 32'h1);
    tick;
    req1 = 0; we1 = 0;
    chk("rw_mem_write", 32'(mem_write), 32'h1);
    chk("rw_mem_data", 32'(mem_data), 32'hC3);
    #2 rst_n = 0;
    #1;
    chk("rw_drop_write", 32'(mem_write), 32'h0);
    chk("rw_released", 32'(mem_data), 32'h5A);
    chk("rw_addr_rst", 32'(mem_addr), 32'h0);
    rst_n = 1;
    tick;
    tick;
    chk("rw_no_commit", 32'(mem[8'h40]), 32'h1A);
    chk("rw_valid", 32'({rd_valid0, rd_valid1}), 32'h0);
    chk("rw_rd_data0", 32'(rd_data0), 32'h0);
    chk("rw_rd_data1", 32'(rd_data1), 32'h0);
    chk("rw_lock_err", 32'(lock_err), 32'h0);

    // reset aborts an in-flight read
    req1 = 1; addr1 = 16'h0030;
    #1 chk("ra_gnt1", 32'(gnt1), 32'h1);
    tick;
    req1 = 0;
    #2 rst_n = 0;
    #1 rst_n = 1;
    tick;
    chk("ra_no_valid", 32'(rd_valid1), 32'h0);
    tick;
    chk("ra_no_valid2", 32'(rd_valid1), 32'h0);
    chk("ra_data", 32'(rd_data1), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
